// File: rtl/delta_sigma_mc_if.sv
// delta_sigma_mc_if: sample handshake bus between a sample source and the modulator
// Signals: data (packed per-channel samples), sample_valid, sample_ready.
// Modports: master = sample source (FIFO/DMA), slave = modulator.
interface delta_sigma_mc_if #(
    parameter int DATA_SIZE = 16,
    parameter int CHANNELS  = 2
);
    logic [CHANNELS*DATA_SIZE-1:0] data;
    logic                          sample_valid;
    logic                          sample_ready;
    modport master (output data, sample_valid, input sample_ready);
    modport slave  (input data, sample_valid, output sample_ready);
endinterface

// File: rtl/delta_sigma_mc.sv
// delta_sigma_mc: multi-channel first/second-order delta-sigma DAC modulator
// Ports: clk; reset (async active-low); bus (slave: data, sample_valid, sample_ready);
//   order2 (0 first-order, 1 second-order, taken at frame boundaries);
//   dataOut (registered 1-bit streams); frame_strobe / underrun (1-cycle pulses after a boundary).
// Optional: define DELTA_SIGMA_DITHER_EN to subtract a 16-bit LFSR bit from the quantizer input.
module delta_sigma_mc #(
    parameter int DATA_SIZE = 16,
    parameter int CHANNELS  = 2,
    parameter int OSR_LOG2  = 6
) (
    input  logic                clk,
    input  logic                reset,
    delta_sigma_mc_if.slave     bus,
    input  logic                order2,
    output logic [CHANNELS-1:0] dataOut,
    output logic                frame_strobe,
    output logic                underrun
);
    localparam int W = DATA_SIZE + 4;
    localparam int S = W + 2;
    localparam logic signed [S-1:0] HALF = S'(1) <<< (DATA_SIZE - 1);
    localparam logic signed [S-1:0] MAX  = (S'(1) <<< (W - 1)) - S'(1);
    localparam logic signed [S-1:0] MIN  = -(S'(1) <<< (W - 1));
    localparam logic [DATA_SIZE-1:0] MID = {1'b1, {(DATA_SIZE-1){1'b0}}};

    logic [OSR_LOG2-1:0]           cnt;
    logic                          pending;
    logic                          mode;
    logic [CHANNELS*DATA_SIZE-1:0] buffer;
    logic [CHANNELS*DATA_SIZE-1:0] active;
    logic                          boundary;
    logic                          transfer;
    logic                          clear;

    function automatic logic signed [W-1:0] sat(input logic signed [S-1:0] v);
        return v > MAX ? MAX[W-1:0] : v < MIN ? MIN[W-1:0] : v[W-1:0];
    endfunction

    assign boundary         = &cnt;
    assign transfer         = bus.sample_valid && !pending;
    assign clear            = boundary && (order2 != mode);
    assign bus.sample_ready = !pending;

    // A boundary only consumes the buffer when pending, and a transfer only happens
    // when not pending, so the two never contend for the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            pending      <= 1'b0;
            mode         <= 1'b0;
            buffer       <= '0;
            active       <= {CHANNELS{MID}};
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            cnt          <= cnt + 1'b1;
            pending      <= transfer | (pending & ~boundary);
            buffer       <= transfer ? bus.data : buffer;
            active       <= (boundary && pending) ? buffer : active;
            mode         <= boundary ? order2 : mode;
            frame_strobe <= boundary;
            underrun     <= boundary & ~pending;
        end
    end

`ifdef DELTA_SIGMA_DITHER_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [W-1:0] i1, i2, i1_n, i2_n, q;
        logic signed [S-1:0] x, f, d, qd;
        logic                o;
`ifdef DELTA_SIGMA_DITHER_EN
        assign d = S'(lfsr[c % 16]);
`else
        assign d = '0;
`endif
        always_comb begin
            x    = S'($signed({1'b0, active[c*DATA_SIZE +: DATA_SIZE]})) - HALF;
            f    = o ? HALF : -HALF;
            i1_n = sat(S'(i1) + x - f);
            i2_n = mode ? sat(S'(i2) + S'(i1_n) - f) : '0;
            q    = mode ? i2_n : i1_n;
            qd   = S'(q) - d;
        end
        // A mode change restarts the loop from zero so the new order starts clean.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset || clear) begin
                i1 <= '0;
                i2 <= '0;
                o  <= 1'b0;
            end else begin
                i1 <= i1_n;
                i2 <= i2_n;
                o  <= !qd[S-1];
            end
        end
        assign dataOut[c] = o;
    end
endmodule
